instruction_fetch_unit: RTL
===========================

Name: instruction_fetch_unit

Overview:
- IF stage of the 16-bit pipelined CPU; sits directly upstream of the 2-way, 4-word-line instruction cache.
- Owns the PC and drives the cache's word address, read request and fill-abort flush; waits out miss fills; accepts branch/jump redirects.
- Produces the IF/ID pipeline register and the retired-fetch counter, which the cache uses as its LRU timestamp.
- A one-entry hold buffer absorbs an instruction that returns while decode is stalled.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- o_fetch_address  out  16  word address to cache; equals current PC.
- o_read  out  1  fetch request to cache.
- i_hit  in  1  cache hit/fill-complete; valid in the same cycle as the request.
- i_instruction  in  16  cache read data; valid when i_hit=1.
- o_flush  out  1  one-cycle abort of an in-flight cache fill.
- i_stall  in  1  decode stall from hazard unit; IF/ID must hold.
- i_redirect  in  1  taken branch/jump resolved this cycle.
- i_redirect_target  in  16  new PC for the redirect.
- o_ifid_valid  out  1  IF/ID register holds a real instruction.
- o_ifid_instruction  out  16  fetched instruction; 16'hb000 (NOP encoding) when invalid.
- o_ifid_pc  out  16  PC of the IF/ID instruction.
- o_instruction_count  out  16  count of instructions delivered into IF/ID.

Behaviour:
- Reset (any cycle, overrides everything, including mid-miss):
  - state=FETCH; PC=RESET_PC; hold buffer empty.
  - o_ifid_valid=0; o_ifid_instruction=16'hb000; o_ifid_pc=0; o_instruction_count=0; o_flush=0.
  - Aborting a cache fill on reset is the cache's own reset duty.
- Combinational outputs:
  - o_fetch_address = PC.
  - o_read = 1 only in FETCH or MISS; 0 in HOLD and FLUSH.
- Priority each cycle: reset > i_redirect > hit/stall handling.
- FETCH state:
  - i_hit=1, i_stall=0: IF/ID <= {1, i_instruction, PC}; PC<=PC+1 (16-bit wrap, FFFF->0000); count<=count+1 (wraps); stay in FETCH.
  - i_hit=1, i_stall=1: hold buffer <= {i_instruction, PC}; PC<=PC+1; go to HOLD; IF/ID unchanged.
  - i_hit=0: go to MISS; PC and o_read stay stable. Zero-latency hits give 1 instruction per cycle.
- MISS state:
  - Keep address and o_read stable until i_hit=1, then act as FETCH on a hit (deliver or capture).
  - If i_stall=0 with no hit, IF/ID is a bubble (valid=0, instruction=b000).
- HOLD state:
  - While i_stall=1: IF/ID and hold buffer unchanged.
  - On i_stall=0: IF/ID <= hold buffer; count++; hold emptied; go to FETCH.
- IF/ID generally:
  - i_stall=1 freezes IF/ID in every state.
  - Any non-stalled cycle without a delivery writes a bubble.
- Redirect (i_redirect=1, any state):
  - PC<=i_redirect_target; hold emptied; IF/ID <= bubble, overriding i_stall; the cycle's hit is discarded and count is not incremented.
  - Fill in flight = state MISS, or state FETCH with i_hit=0 (cache has latched the miss). If a fill is in flight, go to FLUSH; else go to FETCH.
- FLUSH state:
  - o_flush=1 for exactly this one cycle; o_read=0.
  - Next state FETCH at the target.
  - A second redirect in FLUSH updates PC and stays one more FLUSH cycle.
- o_flush is never asserted outside FLUSH.

Test Plan:
- Four sequential hits at PC 0..3, no stall -> IF/ID valid on 4 consecutive cycles, pc 0,1,2,3; count=4; o_read constant 1.
- Cold miss at PC 0x0010, cache model hits 6 cycles later with 0x1234 -> address held at 0x0010 for all miss cycles; bubbles meanwhile; IF/ID={1,0x1234,0x0010} the cycle after the hit; count=1.
- Hit while i_stall=1 for 3 cycles -> o_read=0, IF/ID frozen, PC already +1; on release IF/ID gets the held instruction next cycle; no duplicate or lost instruction.
- Redirect to 0x0040 in the 3rd miss cycle -> o_flush=1 for exactly one cycle with o_read=0, then address=0x0040 with o_read=1; the aborted instruction never appears; count unchanged.
- Redirect while i_hit=1 and HOLD full -> hold cleared, IF/ID bubble, no o_flush, next address=target.
- PC=0xFFFF hit -> next address 0x0000; count 0xFFFF+1 -> 0x0000; reset asserted mid-MISS -> next cycle PC=RESET_PC, IF/ID invalid/b000, o_flush=0.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
//=============================================================================
// Module      : instruction_fetch_unit
// Description : IF stage of the 16-bit pipelined CPU. Owns the PC, issues
//               word fetches to the 2-way instruction cache, waits out miss
//               fills, aborts fills on redirect and maintains the IF/ID
//               pipeline register together with a one-entry hold buffer
//               and a retired-fetch counter (the cache's LRU timestamp).
// Revision    : 1.0 - initial release
//=============================================================================
module instruction_fetch_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        reset,
   // cache interface
   output logic [15:0] o_fetch_address,
   output logic        o_read,
   input  logic        i_hit,
   input  logic [15:0] i_instruction,
   output logic        o_flush,
   // pipeline control
   input  logic        i_stall,
   input  logic        i_redirect,
   input  logic [15:0] i_redirect_target,
   // IF/ID register
   output logic        o_ifid_valid,
   output logic [15:0] o_ifid_instruction,
   output logic [15:0] o_ifid_pc,
   output logic [15:0] o_instruction_count
);

   // Encoding the decoder treats as a no-op; used for every bubble.
   localparam logic [15:0] NOP_INSTRUCTION = 16'hb000;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,   // request issued, expecting a zero-latency hit
      ST_MISS  = 2'd1,   // cache is filling; address held stable
      ST_HOLD  = 2'd2,   // fetched word parked while decode is stalled
      ST_FLUSH = 2'd3    // one-cycle abort of an in-flight fill
   } state_t;

   state_t      state;
   state_t      state_next;

   logic [15:0] pc;
   logic [15:0] pc_next;

   // hold buffer
   logic        hold_valid;
   logic        hold_valid_next;
   logic [15:0] hold_instruction;
   logic [15:0] hold_instruction_next;
   logic [15:0] hold_pc;
   logic [15:0] hold_pc_next;

   // IF/ID register
   logic        ifid_valid;
   logic        ifid_valid_next;
   logic [15:0] ifid_instruction;
   logic [15:0] ifid_instruction_next;
   logic [15:0] ifid_pc;
   logic [15:0] ifid_pc_next;

   logic [15:0] instruction_count;
   logic [15:0] instruction_count_next;

   logic        requesting;
   logic        fill_in_flight;

   // Cache-facing outputs are pure decodes of state and PC.
   always_comb begin
      requesting      = (state == ST_FETCH) || (state == ST_MISS);
      o_read          = requesting;
      o_flush         = (state == ST_FLUSH);
      o_fetch_address = pc;
      // A fill is live once the cache has seen a missed request; a redirect
      // arriving in FLUSH also keeps us in FLUSH for one more cycle.
      fill_in_flight  = (state == ST_MISS)
                     || ((state == ST_FETCH) && !i_hit)
                     || (state == ST_FLUSH);
   end

   // Next-state, PC, hold buffer, IF/ID and counter updates.
   always_comb begin
      state_next             = state;
      pc_next                = pc;
      hold_valid_next        = hold_valid;
      hold_instruction_next  = hold_instruction;
      hold_pc_next           = hold_pc;
      ifid_valid_next        = ifid_valid;
      ifid_instruction_next  = ifid_instruction;
      ifid_pc_next           = ifid_pc;
      instruction_count_next = instruction_count;

      if (i_redirect) begin
         // Redirect wins over stall: the wrong-path slot becomes a bubble
         // and any word returned this cycle is dropped.
         pc_next               = i_redirect_target;
         hold_valid_next       = 1'b0;
         ifid_valid_next       = 1'b0;
         ifid_instruction_next = NOP_INSTRUCTION;
         state_next            = fill_in_flight ? ST_FLUSH : ST_FETCH;
      end else begin
         case (state)
            ST_FETCH, ST_MISS: begin
               if (i_hit) begin
                  pc_next = pc + 16'd1;
                  if (!i_stall) begin
                     ifid_valid_next        = 1'b1;
                     ifid_instruction_next  = i_instruction;
                     ifid_pc_next           = pc;
                     instruction_count_next = instruction_count + 16'd1;
                     state_next             = ST_FETCH;
                  end else begin
                     hold_valid_next       = 1'b1;
                     hold_instruction_next = i_instruction;
                     hold_pc_next          = pc;
                     state_next            = ST_HOLD;
                  end
               end else begin
                  state_next = ST_MISS;
                  if (!i_stall) begin
                     ifid_valid_next       = 1'b0;
                     ifid_instruction_next = NOP_INSTRUCTION;
                  end
               end
            end

            ST_HOLD: begin
               if (!i_stall) begin
                  ifid_valid_next        = hold_valid;
                  ifid_instruction_next  = hold_instruction;
                  ifid_pc_next           = hold_pc;
                  instruction_count_next = instruction_count
                                         + {15'd0, hold_valid};
                  hold_valid_next        = 1'b0;
                  state_next             = ST_FETCH;
               end
            end

            ST_FLUSH: begin
               // Cache output is ignored while the abort is signalled.
               state_next = ST_FETCH;
               if (!i_stall) begin
                  ifid_valid_next       = 1'b0;
                  ifid_instruction_next = NOP_INSTRUCTION;
               end
            end

            default: begin
               state_next = ST_FETCH;
            end
         endcase
      end
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state             <= ST_FETCH;
         pc                <= RESET_PC;
         hold_valid        <= 1'b0;
         hold_instruction  <= NOP_INSTRUCTION;
         hold_pc           <= 16'd0;
         ifid_valid        <= 1'b0;
         ifid_instruction  <= NOP_INSTRUCTION;
         ifid_pc           <= 16'd0;
         instruction_count <= 16'd0;
      end else begin
         state             <= state_next;
         pc                <= pc_next;
         hold_valid        <= hold_valid_next;
         hold_instruction  <= hold_instruction_next;
         hold_pc           <= hold_pc_next;
         ifid_valid        <= ifid_valid_next;
         ifid_instruction  <= ifid_instruction_next;
         ifid_pc           <= ifid_pc_next;
         instruction_count <= instruction_count_next;
      end
   end

   assign o_ifid_valid        = ifid_valid;
   assign o_ifid_instruction  = ifid_instruction;
   assign o_ifid_pc           = ifid_pc;
   assign o_instruction_count = instruction_count;

endmodule
`default_nettype wire
